gray_stream_checker: RTL and testbench

- Consumes the code stream produced by the 3-bit Gray counter stage and converts each sample to binary.
- Checks that consecutive samples are legal Gray successors: hold, a +1 step, or a wrap from max to 0.
- Counts wrap events and latches a sticky error on any illegal transition.
- Sits directly downstream of the Gray counter; its outputs feed display and debug logic.

---
 rtl/gray_stream_checker_if.sv | 26 ++
 rtl/gray_stream_checker.sv | 99 +++++++++
 tb/tb_gray_stream_checker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/gray_stream_checker_if.sv
// Gray sample stream and checker status bundle.
// The master drives Gray; the slave (checker) returns status.
interface gray_stream_checker_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] Gray;
  logic [WIDTH-1:0] Binary;
  logic             Valid;
  logic             Step;
  logic             Wrap;
  logic [CNT_W-1:0] WrapCount;
  logic             Error;

  modport master (
    output Gray,
    input  Binary, Valid, Step, Wrap,
    input  WrapCount, Error
  );

  modport slave (
    input  Gray,
    output Binary, Valid, Step, Wrap,
    output WrapCount, Error
  );
endinterface

// File: rtl/gray_stream_checker.sv
// Gray-to-binary converter that checks each sample is a legal
// successor (hold, +1, wrap), counts wraps and latches errors.
module gray_stream_checker #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
) (
  input  logic Clk,
  input  logic Reset,
  gray_stream_checker_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    ERR
  } state_t;

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  always_comb begin
    cur = bus.Gray;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      cur[i] = cur[i+1] ^ bus.Gray[i];
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = cur;
    valid_d = 1'b1;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        state_d = TRACK;
      end
      TRACK: begin
        if (cur == bin_q) begin
          step_d = 1'b0;
        end else if (bin_q != MAX &&
                     cur == WIDTH'(bin_q + 1'b1)) begin
          step_d = 1'b1;
        end else if (bin_q == MAX && cur == '0) begin
          wrap_d = 1'b1;
          if (cnt_q != CMAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.Binary    = bin_q;
  assign bus.Valid     = valid_q;
  assign bus.Step      = step_q;
  assign bus.Wrap      = wrap_q;
  assign bus.WrapCount = cnt_q;
  assign bus.Error     = err_q;
endmodule

// File: tb/tb_gray_stream_checker.sv
// Directed bench for gray_stream_checker with a
// reference model feeding an expected-result queue.
module tb_gray_stream_checker;
  localparam int W = 3;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_stream_checker_if #(.WIDTH(W), .CNT_W(C)) bus ();

  gray_stream_checker #(.WIDTH(W), .CNT_W(C)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0] bin;
    logic       valid;
    logic       step;
    logic       wrap;
    logic [3:0] cnt;
    logic       err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int nstep;

  logic       m_valid;
  logic       m_err;
  logic [2:0] m_prev;
  logic [3:0] m_cnt;

  function automatic logic [2:0] g2b(logic [2:0] g);
    for (int i = 0; i < 8; i++) begin
      if (((i ^ (i >> 1)) & 7) == int'(g)) return i[2:0];
    end
    return 3'd0;
  endfunction

  function automatic logic [2:0] b2g(logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_prev  = 3'd0;
    m_cnt   = 4'd0;
  endtask

  task automatic model_push(logic [2:0] g);
    exp_t e;
    logic [2:0] cur;
    cur    = g2b(g);
    e.step = 1'b0;
    e.wrap = 1'b0;
    if (!m_valid) begin
      m_valid = 1'b1;
    end else if (m_err) begin
      e.step = 1'b0;
    end else if (cur == m_prev) begin
      e.step = 1'b0;
    end else if (m_prev != 3'd7 && int'(cur) == int'(m_prev) + 1) begin
      e.step = 1'b1;
    end else if (m_prev == 3'd7 && cur == 3'd0) begin
      e.wrap = 1'b1;
      if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
    end else begin
      m_err = 1'b1;
    end
    m_prev  = cur;
    e.bin   = cur;
    e.valid = m_valid;
    e.cnt   = m_cnt;
    e.err   = m_err;
    q.push_back(e);
  endtask

  task automatic compare_all(string tag, exp_t e);
    chk({tag, ".bin"}, 32'(bus.Binary), 32'(e.bin));
    chk({tag, ".valid"}, 32'(bus.Valid), 32'(e.valid));
    chk({tag, ".step"}, 32'(bus.Step), 32'(e.step));
    chk({tag, ".wrap"}, 32'(bus.Wrap), 32'(e.wrap));
    chk({tag, ".cnt"}, 32'(bus.WrapCount), 32'(e.cnt));
    chk({tag, ".err"}, 32'(bus.Error), 32'(e.err));
  endtask

  task automatic drive_gray(string tag, logic [2:0] g);
    exp_t e;
    bus.Gray = g;
    model_push(g);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, ".qempty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      compare_all(tag, e);
    end
    nstep += int'(bus.Step);
  endtask

  task automatic drive_bin(string tag, logic [2:0] b);
    drive_gray(tag, b2g(b));
  endtask

  task automatic check_zero(string tag);
    exp_t z;
    z = '{bin: 3'd0, valid: 1'b0, step: 1'b0,
          wrap: 1'b0, cnt: 4'd0, err: 1'b0};
    compare_all(tag, z);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    model_clear();
    q.delete();
    @(posedge clk);
    #1;
    check_zero(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.Gray = 3'b000;
    nstep = 0;
    model_clear();

    do_reset("rst0");

    nstep = 0;
    for (int b = 0; b < 8; b++) drive_bin("seq", 3'(b));
    chk("seq.nstep", 32'(nstep), 32'd7);

    drive_gray("wrap1", 3'b000);
    chk("wrap1.pulse", 32'(bus.Wrap), 32'd1);
    chk("wrap1.cnt", 32'(bus.WrapCount), 32'd1);
    drive_bin("wrap1.after", 3'd1);
    chk("wrap1.one", 32'(bus.Wrap), 32'd0);

    for (int c = 0; c < 20; c++) begin
      for (int b = 2; b < 8; b++) drive_bin("cyc", 3'(b));
      drive_bin("cyc.w", 3'd0);
      drive_bin("cyc.s", 3'd1);
    end
    chk("sat", 32'(bus.WrapCount), 32'd15);

    drive_gray("hold.a", 3'b011);
    for (int i = 0; i < 5; i++) drive_gray("hold", 3'b011);
    chk("hold.bin", 32'(bus.Binary), 32'd2);
    chk("hold.err", 32'(bus.Error), 32'd0);

    do_reset("rst1");
    drive_gray("e1.first", 3'b001);
    drive_gray("e1.jump", 3'b010);
    chk("e1.err", 32'(bus.Error), 32'd1);
    drive_gray("e1.s4", 3'b110);
    drive_gray("e1.s5", 3'b111);
    chk("e1.bin", 32'(bus.Binary), 32'd5);
    chk("e1.nostep", 32'(bus.Step), 32'd0);

    do_reset("rst2");
    drive_gray("e2.first", 3'b011);
    drive_gray("e2.dec", 3'b001);
    chk("e2.err", 32'(bus.Error), 32'd1);

    do_reset("rst3");
    drive_bin("m.first", 3'd0);
    for (int c = 0; c < 5; c++) begin
      for (int b = 1; b < 8; b++) drive_bin("m.up", 3'(b));
      drive_bin("m.w", 3'd0);
    end
    chk("m.cnt5", 32'(bus.WrapCount), 32'd5);
    drive_bin("m.bad", 3'd2);
    chk("m.err", 32'(bus.Error), 32'd1);

    #2;
    rst = 1'b1;
    #1;
    check_zero("async");
    model_clear();
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    drive_gray("post", 3'b110);
    chk("post.bin", 32'(bus.Binary), 32'd4);
    chk("post.err", 32'(bus.Error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
